// File: rtl/imem_program_loader.sv
// ---------------------------------------------------------------------------
// imem_program_loader
//
// Fills the instruction memory from a word stream before execution. Once the
// program is loaded, it releases the processor and hands the single memory
// address port to the CPU fetch path.
//
// Ports
//   CLK, RST       : rising-edge clock, synchronous active-low reset
//   LoadStart      : pulse; begins a load from IDLE, DONE or ERROR
//   LoadBaseAddr   : byte base address (low two bits ignored)
//   LoadLength     : number of payload words
//   InWordValid/InWord/InWordReady : stream handshake (transfer = valid & ready)
//   CpuFetchAddr   : PC byte address, passed to MemAddr while DONE
//   MemAddr/MemWriteEn/MemWriteData : instruction memory port
//   CpuHold        : processor hold (low only while DONE)
//   LoadDone       : program loaded, CPU running
//   LoadError      : sticky, load aborted
//   WordsLoaded    : words written in the current load
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one extra stream word follows the payload. It is compared
//   against the running sum of the payload words and is not written. A
//   mismatch goes to ERROR and raises ChecksumFail (sticky until LoadStart).
// ---------------------------------------------------------------------------
module imem_program_loader #(
   parameter int INSTR_WIDTH   = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int MEM_DEPTH     = 100
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     LoadStart,
   input  logic [ADDRESS_WIDTH-1:0] LoadBaseAddr,
   input  logic [ADDRESS_WIDTH-1:0] LoadLength,
   input  logic                     InWordValid,
   input  logic [INSTR_WIDTH-1:0]   InWord,
   output logic                     InWordReady,
   input  logic [ADDRESS_WIDTH-1:0] CpuFetchAddr,
   output logic [ADDRESS_WIDTH-1:0] MemAddr,
   output logic                     MemWriteEn,
   output logic [INSTR_WIDTH-1:0]   MemWriteData,
   output logic                     CpuHold,
   output logic                     LoadDone,
   output logic                     LoadError,
`ifdef LOADER_CHECKSUM_EN
   output logic                     ChecksumFail,
`endif
   output logic [ADDRESS_WIDTH-1:0] WordsLoaded
);

   // ST_CSUM is only reachable when the checksum feature is built in.
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_CSUM  = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t                   state_r;
   logic [ADDRESS_WIDTH-1:0] ptr_r;        // word pointer of the next write
   logic [ADDRESS_WIDTH-1:0] remaining_r;  // payload words still expected
   logic                     in_range_s;   // ptr_r addresses a real memory word
`ifdef LOADER_CHECKSUM_EN
   logic [INSTR_WIDTH-1:0]   sum_r;
`endif

   // Memory port mux and stream ready; writes are zero-latency, so these are combinational.
   always_comb begin
      in_range_s   = (ptr_r < ADDRESS_WIDTH'(MEM_DEPTH));
      InWordReady  = 1'b0;
      MemWriteEn   = 1'b0;
      MemWriteData = {INSTR_WIDTH{1'b0}};
      MemAddr      = {ptr_r[ADDRESS_WIDTH-3:0], 2'b00};
      case (state_r)
         ST_LOAD: begin
            // An out-of-range pointer refuses the word so nothing is written.
            if (in_range_s) begin
               InWordReady = 1'b1;
               if (InWordValid) begin
                  MemWriteEn   = 1'b1;
                  MemWriteData = InWord;
               end else begin
                  MemWriteEn   = 1'b0;
               end
            end else begin
               InWordReady = 1'b0;
            end
         end
         ST_CSUM: begin
            InWordReady = 1'b1;
         end
         ST_DONE: begin
            MemAddr = CpuFetchAddr;
         end
         default: begin
            InWordReady = 1'b0;
         end
      endcase
   end

   // Load sequencer: state, pointer, counters and registered status outputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_r     <= ST_IDLE;
         ptr_r       <= {ADDRESS_WIDTH{1'b0}};
         remaining_r <= {ADDRESS_WIDTH{1'b0}};
         WordsLoaded <= {ADDRESS_WIDTH{1'b0}};
         CpuHold     <= 1'b1;
         LoadDone    <= 1'b0;
         LoadError   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         sum_r        <= {INSTR_WIDTH{1'b0}};
         ChecksumFail <= 1'b0;
`endif
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
               if (LoadStart) begin
                  ptr_r       <= LoadBaseAddr >> 2;
                  remaining_r <= LoadLength;
                  WordsLoaded <= {ADDRESS_WIDTH{1'b0}};
                  LoadError   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                  sum_r        <= {INSTR_WIDTH{1'b0}};
                  ChecksumFail <= 1'b0;
`endif
                  if (LoadLength == {ADDRESS_WIDTH{1'b0}}) begin
                     state_r  <= ST_DONE;
                     CpuHold  <= 1'b0;
                     LoadDone <= 1'b1;
                  end else begin
                     state_r  <= ST_LOAD;
                     CpuHold  <= 1'b1;
                     LoadDone <= 1'b0;
                  end
               end
            end
            ST_LOAD: begin
               if (InWordValid && !in_range_s) begin
                  state_r   <= ST_ERROR;
                  LoadError <= 1'b1;
               end else if (InWordValid) begin
                  ptr_r       <= ptr_r + ADDRESS_WIDTH'(1);
                  WordsLoaded <= WordsLoaded + ADDRESS_WIDTH'(1);
                  remaining_r <= remaining_r - ADDRESS_WIDTH'(1);
`ifdef LOADER_CHECKSUM_EN
                  sum_r <= sum_r + InWord;
                  if (remaining_r == ADDRESS_WIDTH'(1)) begin
                     state_r <= ST_CSUM;
                  end
`else
                  if (remaining_r == ADDRESS_WIDTH'(1)) begin
                     state_r  <= ST_DONE;
                     CpuHold  <= 1'b0;
                     LoadDone <= 1'b1;
                  end
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
               if (InWordValid) begin
                  if (InWord == sum_r) begin
                     state_r  <= ST_DONE;
                     CpuHold  <= 1'b0;
                     LoadDone <= 1'b1;
                  end else begin
                     state_r      <= ST_ERROR;
                     LoadError    <= 1'b1;
                     ChecksumFail <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state_r <= ST_IDLE;
               CpuHold <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_program_loader.sv
// Self-checking bench for imem_program_loader: directed scenarios plus random
// loads, checked every cycle against a behavioural reference model and a
// reference memory image.
module tb_imem_program_loader;

   localparam int DEPTH = 100;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST, LoadStart, InWordValid;
   logic [31:0] LoadBaseAddr, LoadLength, InWord, CpuFetchAddr;
   logic        InWordReady, MemWriteEn, CpuHold, LoadDone, LoadError;
   logic [31:0] MemAddr, MemWriteData, WordsLoaded;
`ifdef LOADER_CHECKSUM_EN
   logic        ChecksumFail;
`endif

   imem_program_loader dut (
      .CLK(CLK), .RST(RST), .LoadStart(LoadStart), .LoadBaseAddr(LoadBaseAddr),
      .LoadLength(LoadLength), .InWordValid(InWordValid), .InWord(InWord),
      .InWordReady(InWordReady), .CpuFetchAddr(CpuFetchAddr), .MemAddr(MemAddr),
      .MemWriteEn(MemWriteEn), .MemWriteData(MemWriteData), .CpuHold(CpuHold),
      .LoadDone(LoadDone), .LoadError(LoadError),
`ifdef LOADER_CHECKSUM_EN
      .ChecksumFail(ChecksumFail),
`endif
      .WordsLoaded(WordsLoaded)
   );

   always #5 CLK = ~CLK;

   // Memory image as seen through the DUT write port, and the expected image.
   logic [31:0] dut_mem [0:127];
   logic [31:0] ref_mem [0:127];
   always @(posedge CLK) if (MemWriteEn) dut_mem[MemAddr[8:2]] <= MemWriteData;

   // Reference model state
   typedef enum {P_IDLE, P_LOAD, P_CSUM, P_DONE, P_ERR} phase_e;
   phase_e      ph;
   logic [31:0] m_ptr, m_rem, m_cnt, m_sum;
   bit          m_err, m_cfail;
   int          vectors = 0;
   int          errs = 0;
   logic [31:0] words_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      ph = P_IDLE; m_ptr = 0; m_rem = 0; m_cnt = 0; m_sum = 0; m_err = 0; m_cfail = 0;
   endtask

   // One clock: drive at negedge, check outputs 1ns later, advance model, wait posedge.
   task automatic cycle(input bit rst, input bit start, input logic [31:0] base,
                        input logic [31:0] len, input bit valid,
                        input logic [31:0] word, input logic [31:0] fetch);
      bit          in_rng, e_ready, e_we;
      logic [31:0] e_addr, e_data;
      @(negedge CLK);
      RST = rst; LoadStart = start; LoadBaseAddr = base; LoadLength = len;
      InWordValid = valid; InWord = word; CpuFetchAddr = fetch;
      #1;
      in_rng  = (m_ptr < DEPTH);
      e_ready = (ph == P_LOAD && in_rng) || ph == P_CSUM;
      e_we    = (ph == P_LOAD) && in_rng && valid;
      e_addr  = (ph == P_DONE) ? fetch : (m_ptr << 2);
      e_data  = e_we ? word : 32'd0;
      chk("ready",  {31'd0, InWordReady}, {31'd0, e_ready});
      chk("we",     {31'd0, MemWriteEn},  {31'd0, e_we});
      chk("addr",   MemAddr, e_addr);
      chk("wdata",  MemWriteData, e_data);
      chk("hold",   {31'd0, CpuHold},   {31'd0, ph != P_DONE});
      chk("done",   {31'd0, LoadDone},  {31'd0, ph == P_DONE});
      chk("err",    {31'd0, LoadError}, {31'd0, m_err});
      chk("words",  WordsLoaded, m_cnt);
`ifdef LOADER_CHECKSUM_EN
      chk("cfail",  {31'd0, ChecksumFail}, {31'd0, m_cfail});
`endif
      if (!rst) begin
         model_reset();
      end else begin
         case (ph)
            P_IDLE, P_DONE, P_ERR: if (start) begin
               m_ptr = base >> 2; m_rem = len; m_cnt = 0; m_sum = 0;
               m_err = 0; m_cfail = 0;
               ph = (len == 0) ? P_DONE : P_LOAD;
            end
            P_LOAD: if (valid) begin
               if (m_ptr >= DEPTH) begin
                  ph = P_ERR; m_err = 1;
               end else begin
                  ref_mem[m_ptr[6:0]] = word;
                  m_ptr++; m_cnt++; m_rem--; m_sum += word;
                  if (m_rem == 0) ph = CSUM_EN ? P_CSUM : P_DONE;
               end
            end
            P_CSUM: if (valid) begin
               if (word == m_sum) ph = P_DONE;
               else begin ph = P_ERR; m_err = 1; m_cfail = 1; end
            end
            default: ;
         endcase
      end
      @(posedge CLK);
   endtask

   // Start a load and stream until the model finishes. valid_pct<0 alternates valid.
   task automatic run_load(input logic [31:0] base, input logic [31:0] len,
                           input int valid_pct, input bit good_sum);
      bit          v;
      logic [31:0] w;
      cycle(1'b1, 1'b1, base, len, 1'b0, 32'd0, 32'd0);
      for (int n = 0; n < 400 && (ph == P_LOAD || ph == P_CSUM); n++) begin
         v = (valid_pct < 0) ? (n % 2 == 0) : ($urandom_range(99) < valid_pct);
         if (ph == P_CSUM) w = good_sum ? m_sum : m_sum + 32'd1;
         else if (v && words_q.size() > 0) w = words_q.pop_front();
         else w = $urandom;
         cycle(1'b1, 1'b0, base, len, v, w, $urandom);
      end
      if (ph == P_LOAD || ph == P_CSUM) begin
         vectors++; errs++;
         $error("FAIL load_timeout observed=busy expected=finished");
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin dut_mem[i] = 32'd0; ref_mem[i] = 32'd0; end
      RST = 1'b0; LoadStart = 1'b0; LoadBaseAddr = 32'd0; LoadLength = 32'd0;
      InWordValid = 1'b0; InWord = 32'd0; CpuFetchAddr = 32'd0;
      repeat (2) @(posedge CLK);
      model_reset();
      cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
      cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);

      // 1: back-to-back program
      words_q = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
      run_load(32'd0, 32'd4, 100, 1'b1);
      chk("t1_words", WordsLoaded, 32'd4);
      chk("t1_done",  {31'd0, LoadDone}, 32'd1);
      chk("t1_hold",  {31'd0, CpuHold},  32'd0);

      // 3: fetch pass-through while running
      cycle(1'b1, 1'b0, 32'd0, 32'd4, 1'b0, 32'd0, 32'h8);

      // 2: same load with alternating valid
      words_q = '{32'h20080005, 32'h20090003, 32'h01095020, 32'hAC0A0000};
      run_load(32'd0, 32'd4, -1, 1'b1);
      chk("t2_words", WordsLoaded, 32'd4);

      // 4: overflow past the last memory word
      run_load(32'h18C, 32'd3, 100, 1'b1);
      chk("t4_err",   {31'd0, LoadError}, 32'd1);
      chk("t4_hold",  {31'd0, CpuHold},   32'd1);
      chk("t4_words", WordsLoaded, 32'd1);

      // 5: reset in the middle of a load, then reload elsewhere
      cycle(1'b1, 1'b1, 32'h20, 32'd4, 1'b0, 32'd0, 32'd0);
      cycle(1'b1, 1'b0, 32'h20, 32'd4, 1'b1, 32'h11111111, 32'd0);
      cycle(1'b1, 1'b0, 32'h20, 32'd4, 1'b1, 32'h22222222, 32'd0);
      cycle(1'b0, 1'b0, 32'h20, 32'd4, 1'b0, 32'd0, 32'd0);
      cycle(1'b1, 1'b0, 32'h20, 32'd4, 1'b0, 32'd0, 32'd0);
      run_load(32'h40, 32'd4, 100, 1'b1);

      // 6: zero-length load
      run_load(32'd0, 32'd0, 100, 1'b1);
      chk("t6_done", {31'd0, LoadDone}, 32'd1);
      cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 32'h24);

`ifdef LOADER_CHECKSUM_EN
      words_q = '{32'h1, 32'h2};
      run_load(32'h100, 32'd2, 100, 1'b1);
      chk("cs_ok_done", {31'd0, LoadDone}, 32'd1);
      words_q = '{32'h1, 32'h2};
      run_load(32'h100, 32'd2, 100, 1'b0);
      chk("cs_bad_fail", {31'd0, ChecksumFail}, 32'd1);
      chk("cs_bad_err",  {31'd0, LoadError},    32'd1);
`endif

      // Random loads, some crossing the end of memory
      for (int k = 0; k < 20; k++) begin
         run_load({$urandom_range(99), 2'b00} | 32'($urandom_range(3)),
                  32'($urandom_range(10, 1)), 60, $urandom_range(3) != 0);
         cycle(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0, $urandom);
      end

      for (int i = 0; i < 128; i++) chk("mem", dut_mem[i], ref_mem[i]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
